// File: rtl/morse_encoder.sv
// morse_encoder
//   Turns ASCII bytes from the UART receiver into a timed Morse key waveform
//   and a per-phase symbol code for the display. One character is in flight
//   at a time. Timing is 1 unit dot, 3 unit dash, 1 unit between symbols,
//   3 units after the last symbol of a character and 7 units for a space.
//
// Parameters
//   DOT_CYCLES  cclk cycles per Morse time unit (>= 2)
//   CNT_W       unit-counter width, must hold 7*DOT_CYCLES
//
// Ports
//   cclk         in   1  system clock
//   reset        in   1  synchronous, active-high
//   char_in      in   8  ASCII byte from receiver
//   char_valid   in   1  char_in valid, held until accepted
//   char_ready   out  1  high only in IDLE
//   key_out      out  1  1 = tone/mark, 0 = silence
//   morse_sym    out  2  00 idle/gap, 01 dot, 10 dash, 11 word gap
//   busy         out  1  inverse of char_ready
//   unsupported  out  1  one-cycle pulse when the accepted byte has no code
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a byte, char_ready high
// LOAD      | one cycle: ROM lookup on the latched byte
// MARK      | key on for one dot (1 unit) or dash (3 units)
// SYM_GAP   | key off for 1 unit after every mark
// CHAR_GAP  | key off for 2 more units after the last mark
// WORD_GAP  | key off for 7 units, morse_sym = 11 (space character)

module morse_encoder #(
   parameter int unsigned DOT_CYCLES = 5_000_000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic       cclk,
   input  logic       reset,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       key_out,
   output logic [1:0] morse_sym,
   output logic       busy,
   output logic       unsupported
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MARK,
      ST_SYM_GAP,
      ST_CHAR_GAP,
      ST_WORD_GAP
   } state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_1U   = CNT_W'(DOT_CYCLES)     - ONE;
   localparam logic [CNT_W-1:0] LAST_2U   = CNT_W'(2 * DOT_CYCLES) - ONE;
   localparam logic [CNT_W-1:0] LAST_3U   = CNT_W'(3 * DOT_CYCLES) - ONE;
   localparam logic [CNT_W-1:0] LAST_7U   = CNT_W'(7 * DOT_CYCLES) - ONE;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;
   localparam logic [1:0] SYM_WORD = 2'b11;

   state_t           state_q,  state_d;
   logic [7:0]       char_q,   char_d;
   logic [4:0]       pat_q,    pat_d;
   logic [2:0]       idx_q,    idx_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             key_q,    key_d;
   logic [1:0]       sym_q,    sym_d;
   logic             ready_q,  ready_d;
   logic             busy_q,   busy_d;
   logic             unsup_q,  unsup_d;

   logic [7:0]       fold_char;
   logic [2:0]       rom_len;
   logic [4:0]       rom_pat;
   logic             is_space;
   logic [CNT_W-1:0] phase_last;
   logic             phase_done;

   // Lower-case letters share the upper-case codes.
   always_comb begin
      fold_char = char_q;
      if (char_q >= 8'h61 && char_q <= 8'h7A) begin
         fold_char = char_q - 8'h20;
      end
   end

   assign is_space = (char_q == 8'h20);

   // Pattern is left-aligned: the first symbol sits in bit 4 and the
   // pattern is shifted left after every mark. 1 = dash, 0 = dot.
   // len = 0 marks a byte without a code.
   always_comb begin
      rom_len = 3'd0;
      rom_pat = 5'b00000;
      case (fold_char)
         8'h41: begin rom_len = 3'd2; rom_pat = 5'b01000; end // A .-
         8'h42: begin rom_len = 3'd4; rom_pat = 5'b10000; end // B -...
         8'h43: begin rom_len = 3'd4; rom_pat = 5'b10100; end // C -.-.
         8'h44: begin rom_len = 3'd3; rom_pat = 5'b10000; end // D -..
         8'h45: begin rom_len = 3'd1; rom_pat = 5'b00000; end // E .
         8'h46: begin rom_len = 3'd4; rom_pat = 5'b00100; end // F ..-.
         8'h47: begin rom_len = 3'd3; rom_pat = 5'b11000; end // G --.
         8'h48: begin rom_len = 3'd4; rom_pat = 5'b00000; end // H ....
         8'h49: begin rom_len = 3'd2; rom_pat = 5'b00000; end // I ..
         8'h4A: begin rom_len = 3'd4; rom_pat = 5'b01110; end // J .---
         8'h4B: begin rom_len = 3'd3; rom_pat = 5'b10100; end // K -.-
         8'h4C: begin rom_len = 3'd4; rom_pat = 5'b01000; end // L .-..
         8'h4D: begin rom_len = 3'd2; rom_pat = 5'b11000; end // M --
         8'h4E: begin rom_len = 3'd2; rom_pat = 5'b10000; end // N -.
         8'h4F: begin rom_len = 3'd3; rom_pat = 5'b11100; end // O ---
         8'h50: begin rom_len = 3'd4; rom_pat = 5'b01100; end // P .--.
         8'h51: begin rom_len = 3'd4; rom_pat = 5'b11010; end // Q --.-
         8'h52: begin rom_len = 3'd3; rom_pat = 5'b01000; end // R .-.
         8'h53: begin rom_len = 3'd3; rom_pat = 5'b00000; end // S ...
         8'h54: begin rom_len = 3'd1; rom_pat = 5'b10000; end // T -
         8'h55: begin rom_len = 3'd3; rom_pat = 5'b00100; end // U ..-
         8'h56: begin rom_len = 3'd4; rom_pat = 5'b00010; end // V ...-
         8'h57: begin rom_len = 3'd3; rom_pat = 5'b01100; end // W .--
         8'h58: begin rom_len = 3'd4; rom_pat = 5'b10010; end // X -..-
         8'h59: begin rom_len = 3'd4; rom_pat = 5'b10110; end // Y -.--
         8'h5A: begin rom_len = 3'd4; rom_pat = 5'b11000; end // Z --..
         8'h30: begin rom_len = 3'd5; rom_pat = 5'b11111; end // 0 -----
         8'h31: begin rom_len = 3'd5; rom_pat = 5'b01111; end // 1 .----
         8'h32: begin rom_len = 3'd5; rom_pat = 5'b00111; end // 2 ..---
         8'h33: begin rom_len = 3'd5; rom_pat = 5'b00011; end // 3 ...--
         8'h34: begin rom_len = 3'd5; rom_pat = 5'b00001; end // 4 ....-
         8'h35: begin rom_len = 3'd5; rom_pat = 5'b00000; end // 5 .....
         8'h36: begin rom_len = 3'd5; rom_pat = 5'b10000; end // 6 -....
         8'h37: begin rom_len = 3'd5; rom_pat = 5'b11000; end // 7 --...
         8'h38: begin rom_len = 3'd5; rom_pat = 5'b11100; end // 8 ---..
         8'h39: begin rom_len = 3'd5; rom_pat = 5'b11110; end // 9 ----.
         default: begin rom_len = 3'd0; rom_pat = 5'b00000; end
      endcase
   end

   // Terminal count of the phase currently running.
   always_comb begin
      phase_last = '0;
      case (state_q)
         ST_MARK:     phase_last = pat_q[4] ? LAST_3U : LAST_1U;
         ST_SYM_GAP:  phase_last = LAST_1U;
         ST_CHAR_GAP: phase_last = LAST_2U;
         ST_WORD_GAP: phase_last = LAST_7U;
         default:     phase_last = '0;
      endcase
   end

   assign phase_done = (cnt_q == phase_last);

   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      unsup_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (char_valid && ready_q) begin
               char_d  = char_in;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (is_space) begin
               state_d = ST_WORD_GAP;
            end else if (rom_len == 3'd0) begin
               unsup_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               pat_d   = rom_pat;
               idx_d   = rom_len;
               state_d = ST_MARK;
            end
         end

         ST_MARK: begin
            cnt_d = phase_done ? '0 : cnt_q + ONE;
            if (phase_done) begin
               pat_d   = {pat_q[3:0], 1'b0};
               idx_d   = idx_q - 3'd1;
               state_d = ST_SYM_GAP;
            end
         end

         ST_SYM_GAP: begin
            cnt_d = phase_done ? '0 : cnt_q + ONE;
            if (phase_done) begin
               state_d = (idx_q != 3'd0) ? ST_MARK : ST_CHAR_GAP;
            end
         end

         ST_CHAR_GAP, ST_WORD_GAP: begin
            cnt_d = phase_done ? '0 : cnt_q + ONE;
            if (phase_done) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      key_d   = (state_d == ST_MARK);
      ready_d = (state_d == ST_IDLE);
      busy_d  = ~ready_d;
      case (state_d)
         ST_MARK:     sym_d = pat_d[4] ? SYM_DASH : SYM_DOT;
         ST_WORD_GAP: sym_d = SYM_WORD;
         default:     sym_d = SYM_NONE;
      endcase
   end

   always_ff @(posedge cclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         char_q  <= 8'h00;
         pat_q   <= 5'b00000;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         key_q   <= 1'b0;
         sym_q   <= SYM_NONE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         unsup_q <= 1'b0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         sym_q   <= sym_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         unsup_q <= unsup_d;
      end
   end

   assign char_ready  = ready_q;
   assign key_out     = key_q;
   assign morse_sym   = sym_q;
   assign busy        = busy_q;
   assign unsupported = unsup_q;

endmodule

// File: tb/tb_morse_encoder.sv
module tb_morse_encoder;

   logic       cclk = 1'b0;
   logic       reset;
   logic [7:0] char_in;
   logic       char_valid;
   logic       char_ready;
   logic       key_out;
   logic [1:0] morse_sym;
   logic       busy;
   logic       unsupported;

   int vectors = 0;
   int errors  = 0;

   morse_encoder #(
      .DOT_CYCLES (4),
      .CNT_W      (32)
   ) dut (
      .cclk        (cclk),
      .reset       (reset),
      .char_in     (char_in),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .key_out     (key_out),
      .morse_sym   (morse_sym),
      .busy        (busy),
      .unsupported (unsupported)
   );

   always #5 cclk = ~cclk;

   // Observed vector: {char_ready, busy, key_out, morse_sym[1:0], unsupported}
   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {char_ready, busy, key_out, morse_sym, unsupported};
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed rdy/busy/key/sym/uns=%b required=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   // n consecutive busy cycles with the given key level and symbol code.
   task automatic seg(input string tag, input int n, input logic k, input logic [1:0] s);
      for (int i = 0; i < n; i++) begin
         @(negedge cclk);
         chk(tag, {1'b0, 1'b1, k, s, 1'b0});
      end
   endtask

   // Offer a byte while idle, drop valid after the accept edge, check LOAD.
   task automatic send(input logic [7:0] c, input string tag);
      char_in    = c;
      char_valid = 1'b1;
      @(posedge cclk);
      #1 char_valid = 1'b0;
      @(negedge cclk);
      chk({tag, "_load"}, 6'b010000);
   endtask

   task automatic idle(input string tag);
      @(negedge cclk);
      chk(tag, 6'b100000);
   endtask

   initial begin
      reset      = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
      @(posedge cclk);
      @(negedge cclk);
      chk("reset_state", 6'b100000);
      @(negedge cclk);
      reset = 1'b0;
      idle("idle_after_reset");

      // 'E'
      send(8'h45, "E");
      seg("E_dot", 4, 1'b1, 2'b01);
      seg("E_gap", 12, 1'b0, 2'b00);
      idle("E_idle");

      // 'A'
      send(8'h41, "A");
      seg("A_dot", 4, 1'b1, 2'b01);
      seg("A_sgap", 4, 1'b0, 2'b00);
      seg("A_dash", 12, 1'b1, 2'b10);
      seg("A_cgap", 12, 1'b0, 2'b00);
      idle("A_idle");

      // 'e' folds to 'E'
      send(8'h65, "e");
      seg("e_dot", 4, 1'b1, 2'b01);
      seg("e_gap", 12, 1'b0, 2'b00);
      idle("e_idle");

      // '0' five dashes
      send(8'h30, "zero");
      for (int i = 0; i < 4; i++) begin
         seg("zero_dash", 12, 1'b1, 2'b10);
         seg("zero_sgap", 4, 1'b0, 2'b00);
      end
      seg("zero_dash5", 12, 1'b1, 2'b10);
      seg("zero_cgap", 12, 1'b0, 2'b00);
      idle("zero_idle");

      // 'k' -.-
      send(8'h6B, "k");
      seg("k_dash1", 12, 1'b1, 2'b10);
      seg("k_sgap1", 4, 1'b0, 2'b00);
      seg("k_dot", 4, 1'b1, 2'b01);
      seg("k_sgap2", 4, 1'b0, 2'b00);
      seg("k_dash2", 12, 1'b1, 2'b10);
      seg("k_cgap", 12, 1'b0, 2'b00);
      idle("k_idle");

      // '5' five dots
      send(8'h35, "five");
      for (int i = 0; i < 4; i++) begin
         seg("five_dot", 4, 1'b1, 2'b01);
         seg("five_sgap", 4, 1'b0, 2'b00);
      end
      seg("five_dot5", 4, 1'b1, 2'b01);
      seg("five_cgap", 12, 1'b0, 2'b00);
      idle("five_idle");

      // space: word gap
      send(8'h20, "space");
      seg("space_gap", 28, 1'b0, 2'b11);
      idle("space_idle");

      // '#' unsupported: pulse in the first IDLE cycle, then clear
      send(8'h23, "hash");
      @(negedge cclk);
      chk("hash_pulse", 6'b100001);
      idle("hash_pulse_end");

      // 'T' then 'E' back-to-back with valid held throughout
      char_in    = 8'h54;
      char_valid = 1'b1;
      @(posedge cclk);
      @(negedge cclk);
      chk("TE_T_load", 6'b010000);
      char_in = 8'h45;
      seg("TE_T_dash", 12, 1'b1, 2'b10);
      seg("TE_T_cgap", 12, 1'b0, 2'b00);
      @(negedge cclk);
      chk("TE_idle_between", 6'b100000);
      @(posedge cclk);
      #1 char_valid = 1'b0;
      @(negedge cclk);
      chk("TE_E_load", 6'b010000);
      seg("TE_E_dot", 4, 1'b1, 2'b01);
      seg("TE_E_gap", 12, 1'b0, 2'b00);
      idle("TE_idle1");
      idle("TE_idle2");

      // reset 5 cycles into the dash of 'A'
      send(8'h41, "rstA");
      seg("rstA_dot", 4, 1'b1, 2'b01);
      seg("rstA_sgap", 4, 1'b0, 2'b00);
      seg("rstA_dash", 5, 1'b1, 2'b10);
      reset = 1'b1;
      @(negedge cclk);
      chk("rst_abort", 6'b100000);
      reset = 1'b0;
      idle("rst_idle");

      send(8'h45, "postrst");
      seg("postrst_dot", 4, 1'b1, 2'b01);
      seg("postrst_gap", 12, 1'b0, 2'b00);
      idle("postrst_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
